// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM access arbiter.
// Build option: define RAM_ARB_FIXED_PRIO_EN for fixed A-over-B priority.
package ram_arb_pkg;

  localparam int ADDR_SIZE_DEF = 4;
  localparam int DATA_SIZE_DEF = 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way arbiter. Bit 0 is requester A, bit 1 is requester B; gnt_o is one-hot.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (A wins every conflict).
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_e    last_gnt_i,
  output logic [1:0] gnt_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  // History is irrelevant when A always has priority.
  logic unused_last_gnt;
  assign unused_last_gnt = last_gnt_i;

  // Fixed priority: A first, B only when A is idle.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0])      gnt_o = 2'b01;
    else if (req_i[1]) gnt_o = 2'b10;
  end
`else
  // Round-robin: on a conflict the requester not served last wins.
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_gnt_i == REQ_B)) gnt_o = 2'b01;
    else if (req_i[1])                                   gnt_o = 2'b10;
  end
`endif

endmodule

// File: rtl/ram_access_arbiter.sv
// Sequencer/arbiter in front of an async dual-port RAM: zero-fills the RAM after
// reset, then grants one A/B access per cycle with registered read data.
// Build option: RAM_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req,
  input  logic                 a_we,
  input  logic [ADDR_SIZE-1:0] a_addr,
  input  logic [DATA_SIZE-1:0] a_wdata,
  output logic                 a_gnt,
  output logic                 a_rvalid,
  output logic [DATA_SIZE-1:0] a_rdata,
  input  logic                 b_req,
  input  logic                 b_we,
  input  logic [ADDR_SIZE-1:0] b_addr,
  input  logic [DATA_SIZE-1:0] b_wdata,
  output logic                 b_gnt,
  output logic                 b_rvalid,
  output logic [DATA_SIZE-1:0] b_rdata,
  output logic                 init_done,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDR_SIZE-1:0] mem_wr_addr,
  output logic [ADDR_SIZE-1:0] mem_rd_addr,
  output logic [DATA_SIZE-1:0] mem_wr_data,
  input  logic [DATA_SIZE-1:0] mem_rd_data
);

  localparam int                   DEPTH     = 2 ** ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] INIT_LAST = ADDR_SIZE'(DEPTH - 1);

  state_e                 state_q;
  logic [ADDR_SIZE-1:0]   init_cnt_q;
  logic                   init_done_q;
  req_id_e                last_gnt_q;
  logic                   a_rvalid_q, b_rvalid_q;
  logic [DATA_SIZE-1:0]   a_rdata_q, b_rdata_q;

  logic [1:0]             req, gnt;
  logic                   win_b, win_we, wr_grant, rd_grant;
  logic [ADDR_SIZE-1:0]   win_addr;
  logic [DATA_SIZE-1:0]   win_wdata;

  // Requests are masked (held by the requester, not lost) until zero-fill ends.
  assign req = {b_req, a_req} & {2{state_q == RUN}};

  rr_arbiter2 u_arb (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  assign a_gnt     = gnt[0];
  assign b_gnt     = gnt[1];
  assign win_b     = gnt[1];
  assign win_we    = win_b ? b_we    : a_we;
  assign win_addr  = win_b ? b_addr  : a_addr;
  assign win_wdata = win_b ? b_wdata : a_wdata;
  assign wr_grant  = (|gnt) &  win_we;
  assign rd_grant  = (|gnt) & ~win_we;

  // RAM strobes: zero-fill in INIT, else the winner's single access; idle drives 0.
  always_comb begin
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_addr = '0;
    mem_rd_addr = '0;
    mem_wr_data = '0;
    if (state_q == INIT) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = init_cnt_q;
    end else if (wr_grant) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = win_addr;
      mem_wr_data = win_wdata;
    end else if (rd_grant) begin
      mem_rd_en   = 1'b1;
      mem_rd_addr = win_addr;
    end
  end

  // Control FSM plus registered read returns and arbitration history.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      last_gnt_q  <= REQ_B;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == INIT_LAST) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          if (gnt[0])      last_gnt_q <= REQ_A;
          else if (gnt[1]) last_gnt_q <= REQ_B;
          if (rd_grant) begin
            if (win_b) begin
              b_rvalid_q <= 1'b1;
              b_rdata_q  <= mem_rd_data;
            end else begin
              a_rvalid_q <= 1'b1;
              a_rdata_q  <= mem_rd_data;
            end
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  assign init_done = init_done_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a RAM model and a scoreboard monitor.
module tb_ram_access_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_req, a_we, b_req, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid, init_done;
  logic [7:0] a_rdata, b_rdata;
  logic       mem_wr_en, mem_rd_en;
  logic [3:0] mem_wr_addr, mem_rd_addr;
  logic [7:0] mem_wr_data, mem_rd_data;

  int checks = 0;
  int failures = 0;

  bit         exp_gnt[$];   // 0 = A granted, 1 = B granted
  logic [7:0] exp_a_rd[$];
  logic [7:0] exp_b_rd[$];
  bit         mon_en = 1'b0;
  logic       pend_a = 1'b0, pend_b = 1'b0, rst_s = 1'b1;

  logic [7:0] ram [16];

  always #5 clk = ~clk;

  ram_access_arbiter #(.ADDR_SIZE(4), .DATA_SIZE(8)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .init_done(init_done),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  // Async dual-port RAM: clocked write, combinational read.
  always @(posedge clk) if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
  assign mem_rd_data = ram[mem_rd_addr];

  // Reset value the DUT sampled at the last edge.
  always @(posedge clk) rst_s <= reset;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: grant order, read-return timing and read data against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("wr_rd_exclusive", {31'd0, mem_wr_en & mem_rd_en}, 32'd0);
      if (a_gnt && b_gnt) chk("dual_grant", 32'd1, 32'd0);
      else if (a_gnt || b_gnt) begin
        if (exp_gnt.size() == 0) chk("unexpected_grant", {31'd0, b_gnt}, 32'hFFFF_FFFF);
        else chk("grant_owner", {31'd0, b_gnt}, {31'd0, exp_gnt.pop_front()});
      end
      if (a_rvalid || (pend_a && !rst_s))
        chk("a_rvalid_timing", {31'd0, a_rvalid}, {31'd0, pend_a && !rst_s});
      if (b_rvalid || (pend_b && !rst_s))
        chk("b_rvalid_timing", {31'd0, b_rvalid}, {31'd0, pend_b && !rst_s});
      if (a_rvalid) begin
        if (exp_a_rd.size() == 0) chk("a_unexpected_rdata", {24'd0, a_rdata}, 32'hFFFF_FFFF);
        else chk("a_rdata", {24'd0, a_rdata}, {24'd0, exp_a_rd.pop_front()});
      end
      if (b_rvalid) begin
        if (exp_b_rd.size() == 0) chk("b_unexpected_rdata", {24'd0, b_rdata}, 32'hFFFF_FFFF);
        else chk("b_rdata", {24'd0, b_rdata}, {24'd0, exp_b_rd.pop_front()});
      end
      pend_a <= a_gnt && !a_we;
      pend_b <= b_gnt && !b_we;
    end
  end

  // Called right after reset release: 16 zero-fill writes, then RUN on cycle 16.
  task automatic zero_fill_check(input bit wr_on_16);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("fill_wr_en",   {31'd0, mem_wr_en}, 32'd1);
      chk("fill_addr",    {28'd0, mem_wr_addr}, k);
      chk("fill_data",    {24'd0, mem_wr_data}, 32'd0);
      chk("fill_rd_en",   {31'd0, mem_rd_en}, 32'd0);
      chk("fill_no_gnt",  {31'd0, a_gnt | b_gnt}, 32'd0);
      chk("fill_rvalid",  {31'd0, a_rvalid | b_rvalid}, 32'd0);
      chk("fill_not_done", {31'd0, init_done}, 32'd0);
    end
    @(negedge clk);
    chk("init_done_16", {31'd0, init_done}, 32'd1);
    chk("wr_en_16", {31'd0, mem_wr_en}, {31'd0, wr_on_16});
  endtask

  // Drive one request (aligned just after a rising edge) and hold it until granted.
  task automatic issue(input bit is_b, input bit we, input logic [3:0] addr, input logic [7:0] d);
    bit got = 1'b0;
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = d; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = d; end
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = is_b ? b_gnt : a_gnt;
    end
    if (!got) chk("grant_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (is_b) begin b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; end
    else      begin a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    bit got;
    reset = 1'b1;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    // A write held from before INIT starts; it must wait for RUN.
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd3; a_wdata = 8'hA5;
    exp_gnt.push_back(1'b0);
    @(posedge clk); mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("rst_a_rvalid",  {31'd0, a_rvalid}, 32'd0);
    chk("rst_b_rvalid",  {31'd0, b_rvalid}, 32'd0);
    chk("rst_a_rdata",   {24'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata",   {24'd0, b_rdata}, 32'd0);
    chk("rst_a_gnt",     {31'd0, a_gnt}, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    zero_fill_check(1'b1);
    chk("held_wr_addr", {28'd0, mem_wr_addr}, 32'd3);
    chk("held_wr_data", {24'd0, mem_wr_data}, 32'hA5);
    @(posedge clk); #1 a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;

    // Idle RUN cycle drives everything to zero.
    @(negedge clk);
    chk("idle_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("idle_rd_en", {31'd0, mem_rd_en}, 32'd0);
    chk("idle_addrs", {24'd0, mem_wr_addr, mem_rd_addr}, 32'd0);
    chk("idle_wdata", {24'd0, mem_wr_data}, 32'd0);
    @(posedge clk); #1;

    exp_gnt.push_back(1'b0); exp_a_rd.push_back(8'hA5);
    issue(1'b0, 1'b0, 4'd3, 8'h00);
    exp_gnt.push_back(1'b0); exp_a_rd.push_back(8'h00);
    issue(1'b0, 1'b0, 4'd15, 8'h00);

    // Back-to-back: A alone holds a write for 3 cycles, granted every cycle.
    repeat (3) exp_gnt.push_back(1'b0);
    a_req = 1'b1; a_we = 1'b1; a_addr = 4'd9; a_wdata = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("b2b_a_gnt", {31'd0, a_gnt}, 32'd1);
    end
    @(posedge clk); #1 a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    exp_gnt.push_back(1'b1); exp_b_rd.push_back(8'h3C);
    issue(1'b1, 1'b0, 4'd9, 8'h00);

    // B read granted, reset lands on that same edge: its rvalid must never appear.
    exp_gnt.push_back(1'b1);
    b_req = 1'b1; b_we = 1'b0; b_addr = 4'd3;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin @(negedge clk); got = b_gnt; end
    if (!got) chk("rst_b_grant_timeout", 32'd0, 32'd1);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; b_req = 1'b0; b_addr = '0;
    zero_fill_check(1'b0);
    @(posedge clk); #1;

    // Fresh after reset: A write and B read of address 5 in the same cycle.
    exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1); exp_b_rd.push_back(8'h11);
    fork
      issue(1'b0, 1'b1, 4'd5, 8'h11);
      issue(1'b1, 1'b0, 4'd5, 8'h00);
    join

    // Continuous contention for 6 cycles: A reads 5, B writes 0x22 to 7.
`ifdef RAM_ARB_FIXED_PRIO_EN
    repeat (6) begin exp_gnt.push_back(1'b0); exp_a_rd.push_back(8'h11); end
`else
    repeat (3) begin
      exp_gnt.push_back(1'b0); exp_gnt.push_back(1'b1); exp_a_rd.push_back(8'h11);
    end
`endif
    a_req = 1'b1; a_we = 1'b0; a_addr = 4'd5;
    b_req = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 8'h22;
    repeat (6) @(negedge clk);
    @(posedge clk); #1;
    a_req = 1'b0; a_addr = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    exp_gnt.push_back(1'b1);
`ifdef RAM_ARB_FIXED_PRIO_EN
    exp_b_rd.push_back(8'h00);
`else
    exp_b_rd.push_back(8'h22);
`endif
    issue(1'b1, 1'b0, 4'd7, 8'h00);

    repeat (3) @(negedge clk);
    chk("gnt_queue_drained", exp_gnt.size(), 32'd0);
    chk("a_rd_queue_drained", exp_a_rd.size(), 32'd0);
    chk("b_rd_queue_drained", exp_b_rd.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
